// File: rtl/display_pkg.sv
// Shared constants and the brightness window helper for the 7-segment scan controller.
package display_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [1:0] SLOT_UND = 2'd0;
  localparam logic [1:0] SLOT_DEZ = 2'd1;
  localparam logic [1:0] SLOT_CEN = 2'd2;
  localparam logic [1:0] SLOT_MIL = 2'd3;

  localparam logic [3:0] DSEL_OFF = 4'b1111;

  // Number of lit cycles per slot; (level+1)*span < 2^32 for any realistic TICK_DIV.
  function automatic logic [31:0] on_limit_f(input logic [31:0] span,
                                             input logic [31:0] level,
                                             input int unsigned bright_w);
    logic [31:0] prod;
    prod = (level + 32'd1) * span;
    return prod >> bright_w;
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot timer: cycle counter within a digit slot and the 0..3 slot index.
module display_scan_timer
  import display_pkg::*;
#(
  parameter  int unsigned TICK_DIV = 100000,
  localparam int unsigned CNT_W    = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_o,
  output logic [1:0]       slot_o,
  output logic             slot_end_o,
  output logic             frame_end_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic             slot_end;

  assign slot_end = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (slot_end) begin
      cnt_d  = '0;
      slot_d = slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= SLOT_UND;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign slot_o      = slot_q;
  assign slot_end_o  = slot_end;
  assign frame_end_o = slot_end && (slot_q == SLOT_MIL);

endmodule

// File: rtl/display_scan_ctrl.sv
// Basys3 4-digit 7-segment scan controller: update handshake, frame-aligned apply,
// leading-zero blanking, dead time and brightness window, registered outputs.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DEAD     = 64,
  parameter int unsigned BRIGHT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [15:0]         upd_digits,
  input  logic [3:0]          upd_dp,
  input  logic                blank_lz,
  input  logic [BRIGHT_W-1:0] bright,
  output logic [1:0]          muxsel,
  output logic [3:0]          digit,
  output logic [3:0]          dsel,
  output logic                dp,
  output logic                frame_tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       slot;
  logic             slot_end;
  logic             frame_end;

  display_scan_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .cnt_o       (cnt),
    .slot_o      (slot),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  frame_in_slot_end_a : assert property (@(posedge clk) disable iff (rst) frame_end |-> slot_end);

  // {digits[15:0], dp[3:0]}
  logic [19:0] shadow_q, shadow_d;
  logic [19:0] active_q, active_d;
  logic        pending_q, pending_d;
  logic        accept;

  assign accept    = upd_valid & ~pending_q;
  assign upd_ready = ~pending_q;

  // Accept only happens with pending clear, so it never collides with an apply;
  // a value accepted on the boundary edge waits for the following boundary.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = {upd_digits, upd_dp};
      pending_d = 1'b1;
    end
  end

  logic [15:0] active_digits;
  logic [3:0]  active_dp;
  logic [3:0]  blank_vec;
  logic        zero_run;

  assign active_digits = active_q[19:4];
  assign active_dp     = active_q[3:0];

  always_comb begin
    blank_vec = '0;
    zero_run  = blank_lz;
    for (int unsigned k = 0; k < 3; k++) begin
      zero_run         = zero_run & (active_digits[(3-k)*BCD_W +: BCD_W] == '0);
      blank_vec[3-k]   = zero_run;
    end
  end

  logic [31:0] on_limit;
  logic [31:0] cnt_ext;
  logic        on_window;
  logic        lit;

  assign on_limit  = on_limit_f(32'(TICK_DIV - DEAD), 32'(bright), BRIGHT_W);
  assign cnt_ext   = 32'(cnt);
  assign on_window = (cnt_ext >= DEAD) && (cnt_ext < DEAD + on_limit);
  assign lit       = enable & ~blank_vec[slot] & on_window;

  logic [1:0] muxsel_q, muxsel_d;
  logic [3:0] digit_q, digit_d;
  logic [3:0] dsel_q, dsel_d;
  logic       dp_q, dp_d;
  logic       frame_tick_q, frame_tick_d;

  always_comb begin
    muxsel_d     = slot;
    digit_d      = active_digits[slot*BCD_W +: BCD_W];
    dsel_d       = DSEL_OFF;
    dsel_d[slot] = ~lit;
    dp_d         = ~(active_dp[slot] & lit);
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      muxsel_q     <= SLOT_UND;
      digit_q      <= '0;
      dsel_q       <= DSEL_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      muxsel_q     <= muxsel_d;
      digit_q      <= digit_d;
      dsel_q       <= dsel_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign muxsel     = muxsel_q;
  assign digit      = digit_q;
  assign dsel       = dsel_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two configurations share stimulus, a cycle model checks both.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        upd_valid;
  logic [15:0] upd_digits;
  logic [3:0]  upd_dp;
  logic        blank_lz;
  logic [2:0]  bright;

  logic        upd_ready_w [2];
  logic [1:0]  muxsel_w    [2];
  logic [3:0]  digit_w     [2];
  logic [3:0]  dsel_w      [2];
  logic        dp_w        [2];
  logic        ft_w        [2];

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(.TICK_DIV(8), .DEAD(0), .BRIGHT_W(3)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .upd_valid(upd_valid), .upd_ready(upd_ready_w[0]),
    .upd_digits(upd_digits), .upd_dp(upd_dp), .blank_lz(blank_lz), .bright(bright),
    .muxsel(muxsel_w[0]), .digit(digit_w[0]), .dsel(dsel_w[0]), .dp(dp_w[0]), .frame_tick(ft_w[0])
  );

  display_scan_ctrl #(.TICK_DIV(16), .DEAD(2), .BRIGHT_W(3)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .upd_valid(upd_valid), .upd_ready(upd_ready_w[1]),
    .upd_digits(upd_digits), .upd_dp(upd_dp), .blank_lz(blank_lz), .bright(bright),
    .muxsel(muxsel_w[1]), .digit(digit_w[1]), .dsel(dsel_w[1]), .dp(dp_w[1]), .frame_tick(ft_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          td     [2] = '{8, 16};
  int          dead   [2] = '{0, 2};
  bit          mvalid [2] = '{0, 0};
  int          t      [2];
  logic [19:0] act    [2];
  logic [19:0] shd    [2];
  bit          pnd    [2];
  logic        e_ready[2];
  logic [1:0]  e_mux  [2];
  logic [3:0]  e_dig  [2];
  logic [3:0]  e_dsel [2];
  logic        e_dp   [2];
  logic        e_ft   [2];

  always @(negedge clk) begin
    int c, s, lim;
    bit onw, blanked, lit, bnd, acc;
    for (int i = 0; i < 2; i++) begin
      if (mvalid[i]) begin
        chk($sformatf("dut%0d.upd_ready", i), 32'(upd_ready_w[i]), 32'(e_ready[i]));
        chk($sformatf("dut%0d.muxsel", i),    32'(muxsel_w[i]),    32'(e_mux[i]));
        chk($sformatf("dut%0d.digit", i),     32'(digit_w[i]),     32'(e_dig[i]));
        chk($sformatf("dut%0d.dsel", i),      32'(dsel_w[i]),      32'(e_dsel[i]));
        chk($sformatf("dut%0d.dp", i),        32'(dp_w[i]),        32'(e_dp[i]));
        chk($sformatf("dut%0d.frame_tick", i),32'(ft_w[i]),        32'(e_ft[i]));
      end
      if (rst) begin
        t[i] = 0; act[i] = '0; shd[i] = '0; pnd[i] = 0;
        e_ready[i] = 1'b1; e_mux[i] = 2'd0; e_dig[i] = 4'd0;
        e_dsel[i] = 4'hF; e_dp[i] = 1'b1; e_ft[i] = 1'b0;
        mvalid[i] = 1;
      end else if (mvalid[i]) begin
        c   = t[i] % td[i];
        s   = (t[i] / td[i]) % 4;
        lim = ((int'(bright) + 1) * (td[i] - dead[i])) / 8;
        onw = (c >= dead[i]) && (c < dead[i] + lim);
        blanked = 0;
        if (blank_lz && s > 0) begin
          blanked = 1;
          for (int j = s; j < 4; j++)
            if (((act[i] >> (4 + 4*j)) & 20'hF) != 0) blanked = 0;
        end
        lit        = enable && onw && !blanked;
        e_mux[i]   = 2'(s);
        e_dig[i]   = 4'((act[i] >> (4 + 4*s)) & 20'hF);
        e_dsel[i]  = lit ? ~(4'b0001 << s) : 4'hF;
        e_dp[i]    = !(lit && act[i][s]);
        bnd        = (s == 3) && (c == td[i] - 1);
        e_ft[i]    = bnd;
        acc        = upd_valid && !pnd[i];
        if (bnd && pnd[i]) begin act[i] = shd[i]; pnd[i] = 0; end
        if (acc) begin shd[i] = {upd_digits, upd_dp}; pnd[i] = 1; end
        e_ready[i] = !pnd[i];
        t[i]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int lo_cnt [4];
  int dp_lo, dp_bad;

  // Offer a value, then return at the negedge where the selected DUT has applied it.
  task automatic load(input logic [15:0] v, input logic [3:0] dpv, input int which);
    int n;
    upd_digits = v; upd_dp = dpv; upd_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!upd_ready_w[which] && n < 400);
    @(posedge clk); #1 upd_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!upd_ready_w[which] && n < 400);
    if (!upd_ready_w[which]) begin
      checks++; errors++;
      $display("FAIL load_timeout dut%0d: upd_ready got 0, expected 1", which);
    end
  endtask

  task automatic wait_ft(input int which);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!ft_w[which] && n < 400);
    if (!ft_w[which]) begin
      checks++; errors++;
      $display("FAIL ft_timeout dut%0d: frame_tick got 0, expected 1", which);
    end
  endtask

  task automatic measure(input int which, input int n);
    for (int b = 0; b < 4; b++) lo_cnt[b] = 0;
    dp_lo = 0; dp_bad = 0;
    repeat (n) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) if (!dsel_w[which][b]) lo_cnt[b]++;
      if (!dp_w[which]) begin
        dp_lo++;
        if (dsel_w[which] != 4'b1011) dp_bad++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; upd_valid = 1'b0; upd_digits = '0; upd_dp = '0;
    blank_lz = 1'b0; bright = 3'd7;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Scan order on the 8-cycle configuration
    load(16'h1234, 4'b0000, 0);
    chk("scan.ft_apply", 32'(ft_w[0]), 1);
    @(negedge clk);  chk("scan.dsel0", 32'(dsel_w[0]), 32'hE); chk("scan.dig0", 32'(digit_w[0]), 4);
    repeat (8) @(negedge clk);
    chk("scan.dsel1", 32'(dsel_w[0]), 32'hD); chk("scan.dig1", 32'(digit_w[0]), 3);
    repeat (8) @(negedge clk);
    chk("scan.dsel2", 32'(dsel_w[0]), 32'hB); chk("scan.dig2", 32'(digit_w[0]), 2);
    repeat (8) @(negedge clk);
    chk("scan.dsel3", 32'(dsel_w[0]), 32'h7); chk("scan.dig3", 32'(digit_w[0]), 1);
    repeat (7) @(negedge clk);
    chk("scan.ft_period", 32'(ft_w[0]), 1);

    // Mid-frame offer, then an ignored offer while pending
    repeat (5) @(posedge clk);
    #1 upd_digits = 16'h5678; upd_dp = '0; upd_valid = 1'b1;
    @(posedge clk); #1 upd_valid = 1'b0;
    @(negedge clk); chk("hs.ready_drop", 32'(upd_ready_w[0]), 0);
    chk("hs.old_shown", 32'(muxsel_w[0]) == 1 ? 32'(digit_w[0]) : 32'(digit_w[0]),
        32'(muxsel_w[0]) == 0 ? 4 : (muxsel_w[0] == 1 ? 3 : (muxsel_w[0] == 2 ? 2 : 1)));
    upd_digits = 16'h9999; upd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 upd_valid = 1'b0;
    wait_ft(0);
    @(negedge clk);
    chk("hs.new_dig", 32'(digit_w[0]), 8);
    chk("hs.ready_back", 32'(upd_ready_w[0]), 1);

    // Offer accepted on the boundary edge itself
    wait_ft(0);
    repeat (31) @(posedge clk);
    #1 upd_digits = 16'h4321; upd_valid = 1'b1;
    @(posedge clk); #1 upd_valid = 1'b0;
    @(negedge clk);
    chk("bnd.ft", 32'(ft_w[0]), 1);
    chk("bnd.ready", 32'(upd_ready_w[0]), 0);
    @(negedge clk); chk("bnd.not_bypassed", 32'(digit_w[0]), 8);
    wait_ft(0);
    @(negedge clk); chk("bnd.applied", 32'(digit_w[0]), 1);

    // Leading-zero blanking
    blank_lz = 1'b1;
    load(16'h0007, 4'b0000, 0);
    measure(0, 32);
    chk("blank7.hi_on", 32'(lo_cnt[1] + lo_cnt[2] + lo_cnt[3]), 0);
    chk("blank7.d0_on", 32'(lo_cnt[0]), 8);
    load(16'h0000, 4'b0000, 0);
    @(negedge clk);
    chk("blank0.digit", 32'(digit_w[0]), 0);
    chk("blank0.dsel", 32'(dsel_w[0]), 32'hE);
    measure(0, 32);
    chk("blank0.hi_on", 32'(lo_cnt[1] + lo_cnt[2] + lo_cnt[3]), 0);
    chk("blank0.d0_on", 32'(lo_cnt[0]), 8);
    @(posedge clk); #1 blank_lz = 1'b0;
    @(negedge clk);
    measure(0, 32);
    chk("noblank.d3_on", 32'(lo_cnt[3]), 8);
    chk("noblank.all_on", 32'(lo_cnt[0] + lo_cnt[1] + lo_cnt[2] + lo_cnt[3]), 32);

    // Brightness window and decimal point on the 16-cycle, DEAD=2 configuration
    bright = 3'd3;
    load(16'h1234, 4'b0100, 1);
    measure(1, 64);
    chk("br3.d2_on", 32'(lo_cnt[2]), 7);
    chk("br3.all_on", 32'(lo_cnt[0] + lo_cnt[1] + lo_cnt[2] + lo_cnt[3]), 28);
    chk("br3.dp_on", 32'(dp_lo), 7);
    chk("br3.dp_outside", 32'(dp_bad), 0);
    @(posedge clk); #1 bright = 3'd7;
    @(negedge clk);
    measure(1, 64);
    chk("br7.all_on", 32'(lo_cnt[0] + lo_cnt[1] + lo_cnt[2] + lo_cnt[3]), 56);
    chk("br7.dp_on", 32'(dp_lo), 14);
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    measure(1, 64);
    chk("en0.all_on", 32'(lo_cnt[0] + lo_cnt[1] + lo_cnt[2] + lo_cnt[3]), 0);
    chk("en0.dp_on", 32'(dp_lo), 0);

    // Mid-scan reset with a pending value
    enable = 1'b1;
    @(posedge clk); #1 upd_digits = 16'h9876; upd_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    chk("rst.dsel", 32'(dsel_w[0]), 32'hF);
    chk("rst.dp", 32'(dp_w[0]), 1);
    chk("rst.ready", 32'(upd_ready_w[0]), 1);
    chk("rst.muxsel", 32'(muxsel_w[0]), 0);
    chk("rst.ft", 32'(ft_w[0]), 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!ft_w[0] && n < 100);
    chk("rst.first_frame_len", 32'(n), 32);
    @(negedge clk);
    chk("rst.discarded", 32'(digit_w[0]), 0);
    chk("rst.slot0_dsel", 32'(dsel_w[0]), 32'hE);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
